// File: rtl/hist_readout_clear.sv
// hist_readout_clear
//
// Read/clear engine for port B of the dual-port histogram RAM. A start
// pulse scans bins 0..NUM_BINS-1 and streams each bin count with its
// running, saturating cumulative sum on a valid/ready interface. When
// clear_en is sampled high with the start, every bin is written back to
// zero right after it has been read, leaving the RAM empty for the next
// frame.
//
// Ports:
//   clk, rst      single clock (also clocks RAM port B), sync active-high reset
//   start         scan request pulse, honoured only while idle
//   clear_en      latched with an accepted start; 1 = zero bins after reading
//   busy, done    scan in progress / one-cycle completion pulse
//   ram_addr      port B address
//   ram_wr_en     port B write enable (clear writes only)
//   ram_wr_data   port B write data, always zero
//   ram_rd_data   port B read data, one cycle after the address
//   m_valid/m_ready  output handshake
//   m_bin, m_count, m_cdf, m_last  beat payload (head of a 2-entry FIFO)
module hist_readout_clear #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BINS   = 256,
  parameter int CDF_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  clear_en,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr_en,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH-1:0] m_bin,
  output logic [DATA_WIDTH-1:0] m_count,
  output logic [CDF_WIDTH-1:0]  m_cdf,
  output logic                  m_last
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CLEAR = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_BIN = ADDR_WIDTH'(NUM_BINS - 1);
  localparam logic [CDF_WIDTH-1:0]  CDF_MAX  = '1;

  state_t state;
  state_t state_next;

  logic [ADDR_WIDTH-1:0] bin;
  logic                  clear_lat;
  logic [CDF_WIDTH-1:0]  cdf;

  // Read issued last cycle: its data is on ram_rd_data this cycle
  logic                  rd_pending;
  logic [ADDR_WIDTH-1:0] rd_bin;
  logic                  rd_last;

  logic [ADDR_WIDTH-1:0] fifo_bin   [2];
  logic [DATA_WIDTH-1:0] fifo_count_data [2];
  logic [CDF_WIDTH-1:0]  fifo_cdf   [2];
  logic                  fifo_last  [2];
  logic                  fifo_wr_ptr;
  logic                  fifo_rd_ptr;
  logic [1:0]            fifo_count;

  logic                  is_last;
  logic                  push;
  logic                  pop;
  logic                  room_ok;
  logic                  issue;
  logic                  accept_start;
  logic [CDF_WIDTH:0]    cdf_sum;
  logic [CDF_WIDTH-1:0]  cdf_next;

  // Handshake, flow-control and accumulator arithmetic shared by all
  // processes below.
  always_comb begin
    is_last      = (bin == LAST_BIN);
    accept_start = (state == IDLE) && start;
    push         = rd_pending;
    pop          = (fifo_count != 2'd0) && m_ready;
    // A read may only be issued if its data is guaranteed a FIFO slot when
    // it arrives next cycle, counting the read already in flight.
    room_ok      = (3'(fifo_count) + 3'(rd_pending) - 3'(pop)) < 3'd2;
    issue        = (state == READ) && room_ok;
    cdf_sum      = {1'b0, cdf} + (CDF_WIDTH+1)'(ram_rd_data);
    cdf_next     = cdf_sum[CDF_WIDTH] ? CDF_MAX : cdf_sum[CDF_WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: READ stalls until there is room, CLEAR always takes
  // exactly one cycle, DRAIN waits for the last beat to leave the FIFO.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = READ;
      end
      READ: begin
        if (issue) begin
          if (clear_lat)    state_next = CLEAR;
          else if (is_last) state_next = DRAIN;
        end
      end
      CLEAR: begin
        state_next = is_last ? DRAIN : READ;
      end
      DRAIN: begin
        if ((fifo_count == 2'd0) && !rd_pending) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the state. done fires on the single DRAIN cycle
  // that finds everything flushed, and busy drops in that same cycle.
  always_comb begin
    done        = (state == DRAIN) && (fifo_count == 2'd0) && !rd_pending;
    busy        = (state != IDLE) && !done;
    ram_addr    = ((state == READ) || (state == CLEAR)) ? bin : '0;
    ram_wr_en   = (state == CLEAR);
    ram_wr_data = '0;
  end

  // Scan bookkeeping: bin pointer, latched clear mode, read tracking and
  // the running CDF, which advances as each read result is captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin        <= '0;
      clear_lat  <= 1'b0;
      cdf        <= '0;
      rd_pending <= 1'b0;
      rd_bin     <= '0;
      rd_last    <= 1'b0;
    end else begin
      rd_pending <= issue;
      if (issue) begin
        rd_bin  <= bin;
        rd_last <= is_last;
      end
      if (accept_start) begin
        clear_lat <= clear_en;
        bin       <= '0;
        cdf       <= '0;
      end else begin
        if (((issue && !clear_lat) || (state == CLEAR)) && !is_last) begin
          bin <= bin + 1'b1;
        end
        if (push) cdf <= cdf_next;
      end
    end
  end

  // FIFO pointers and occupancy; a reset flushes any pending beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_wr_ptr <= 1'b0;
      fifo_rd_ptr <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      if (push) fifo_wr_ptr <= ~fifo_wr_ptr;
      if (pop)  fifo_rd_ptr <= ~fifo_rd_ptr;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage needs no reset: the outputs are masked while it is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_bin[fifo_wr_ptr]        <= rd_bin;
      fifo_count_data[fifo_wr_ptr] <= ram_rd_data;
      fifo_cdf[fifo_wr_ptr]        <= cdf_next;
      fifo_last[fifo_wr_ptr]       <= rd_last;
    end
  end

  // Output beat is the FIFO head, forced to zero when nothing is queued.
  always_comb begin
    m_valid = (fifo_count != 2'd0);
    m_bin   = m_valid ? fifo_bin[fifo_rd_ptr]        : '0;
    m_count = m_valid ? fifo_count_data[fifo_rd_ptr] : '0;
    m_cdf   = m_valid ? fifo_cdf[fifo_rd_ptr]        : '0;
    m_last  = m_valid ? fifo_last[fifo_rd_ptr]       : 1'b0;
  end

endmodule

// File: tb/tb_hist_readout_clear.sv
// Testbench for hist_readout_clear with a 512 x 32 read-first RAM model.
module tb_hist_readout_clear;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int NB = 256;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          clear_en;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_addr;
  logic          ram_wr_en;
  logic [DW-1:0] ram_wr_data;
  logic [DW-1:0] ram_rd_data;
  logic          m_valid;
  logic          m_ready;
  logic [AW-1:0] m_bin;
  logic [DW-1:0] m_count;
  logic [CW-1:0] m_cdf;
  logic          m_last;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hist_readout_clear #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_BINS(NB),
    .CDF_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .clear_en(clear_en),
    .busy(busy),
    .done(done),
    .ram_addr(ram_addr),
    .ram_wr_en(ram_wr_en),
    .ram_wr_data(ram_wr_data),
    .ram_rd_data(ram_rd_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_bin(m_bin),
    .m_count(m_count),
    .m_cdf(m_cdf),
    .m_last(m_last)
  );

  // RAM port B model (read-first), with a bulk preload path.
  logic [DW-1:0] mem [512];
  int load_mode = 0;

  always @(posedge clk) begin
    if (load_mode == 1) begin
      for (int i = 0; i < 512; i++) mem[i] <= DW'(i + 1);
    end else if (load_mode == 2) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'hFFFF_FFFF;
    end else if (ram_wr_en) begin
      mem[ram_addr] <= ram_wr_data;
    end
    ram_rd_data <= mem[ram_addr];
  end

  // Results of the latest scan
  logic [AW-1:0] b_bin  [NB];
  logic [DW-1:0] b_cnt  [NB];
  logic [CW-1:0] b_cdf  [NB];
  logic          b_last [NB];
  int            b_cyc  [NB];
  int            nbeats;
  int            done_cyc;
  int            done_pulses;
  int            stall_viol;
  int            bad_wr;
  int            wr_count;
  bit            timed_out;
  logic          busy_at_done;
  logic          busy_c1;
  logic [AW-1:0] addr_c1;

  task automatic preload(input int mode);
    @(negedge clk);
    load_mode = mode;
    @(negedge clk);
    load_mode = 0;
  endtask

  // Runs one scan; cycle 1 is the cycle after the edge that samples start.
  task automatic run_scan(input logic clr, input bit rand_ready, input bit spam);
    int cyc;
    int post;
    bit seen_done;
    bit hold_v;
    logic [AW-1:0] h_bin;
    logic [DW-1:0] h_cnt;
    logic [CW-1:0] h_cdf;
    logic          h_last;
    for (int i = 0; i < NB; i++) begin
      b_bin[i] = 'x; b_cnt[i] = 'x; b_cdf[i] = 'x; b_last[i] = 1'bx; b_cyc[i] = -1;
    end
    nbeats = 0; done_cyc = -1; done_pulses = 0; stall_viol = 0; bad_wr = 0;
    wr_count = 0; timed_out = 0; busy_at_done = 1'bx; busy_c1 = 1'bx; addr_c1 = 'x;
    seen_done = 0; hold_v = 0; post = 0; cyc = 0;
    h_bin = '0; h_cnt = '0; h_cdf = '0; h_last = 1'b0;
    @(negedge clk);
    start = 1'b1;
    clear_en = clr;
    m_ready = 1'b1;
    while (!timed_out && post < 8) begin
      @(negedge clk);
      cyc++;
      if (rand_ready) m_ready = ($urandom_range(0, 9) >= 3);
      if (cyc == 1) begin
        busy_c1 = busy;
        addr_c1 = ram_addr;
      end
      if (ram_wr_en) begin
        wr_count++;
        if (ram_addr >= NB) bad_wr++;
      end
      if (hold_v && (!m_valid || m_bin !== h_bin || m_count !== h_cnt ||
                     m_cdf !== h_cdf || m_last !== h_last)) stall_viol++;
      hold_v = 0;
      if (m_valid && m_ready) begin
        if (nbeats < NB) begin
          b_bin[nbeats] = m_bin; b_cnt[nbeats] = m_count; b_cdf[nbeats] = m_cdf;
          b_last[nbeats] = m_last; b_cyc[nbeats] = cyc;
        end
        nbeats++;
      end else if (m_valid) begin
        hold_v = 1; h_bin = m_bin; h_cnt = m_count; h_cdf = m_cdf; h_last = m_last;
      end
      if (done) begin
        done_pulses++;
        if (!seen_done) begin
          done_cyc = cyc;
          busy_at_done = busy;
        end
        seen_done = 1;
      end
      if (seen_done) post++;
      if (!spam || seen_done) begin
        start = 1'b0;
      end else begin
        start = 1'b1;
        clear_en = ~clear_en;
      end
      if (cyc > 3000) timed_out = 1;
    end
    start = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; clear_en = 1'b0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
    checks++; if (ram_addr !== '0) begin failures++; $display("[TB] FAIL reset_addr got=%0h exp=0", ram_addr); end
    checks++; if (ram_wr_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_en got=%b exp=0", ram_wr_en); end
    checks++; if (ram_wr_data !== '0) begin failures++; $display("[TB] FAIL reset_wr_data got=%0h exp=0", ram_wr_data); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_valid got=%b exp=0", m_valid); end
    checks++; if (m_bin !== '0) begin failures++; $display("[TB] FAIL reset_m_bin got=%0h exp=0", m_bin); end
    checks++; if (m_count !== '0) begin failures++; $display("[TB] FAIL reset_m_count got=%0h exp=0", m_count); end
    checks++; if (m_cdf !== '0) begin failures++; $display("[TB] FAIL reset_m_cdf got=%0h exp=0", m_cdf); end
    checks++; if (m_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_last got=%b exp=0", m_last); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || m_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL idle_after_reset busy=%b m_valid=%b exp 0/0", busy, m_valid);
    end
  endtask

  task automatic test_no_clear;
    logic [CW-1:0] exp_cdf;
    int bad;
    preload(1);
    run_scan(1'b0, 1'b0, 1'b0);
    checks++; if (timed_out) begin failures++; $display("[TB] FAIL noclr_timeout got=1 exp=0"); end
    checks++; if (nbeats !== NB) begin failures++; $display("[TB] FAIL noclr_beats got=%0d exp=%0d", nbeats, NB); end
    checks++; if (busy_c1 !== 1'b1 || addr_c1 !== '0) begin
      failures++; $display("[TB] FAIL noclr_cycle1 busy=%b addr=%0h exp 1/0", busy_c1, addr_c1);
    end
    exp_cdf = '0;
    for (int i = 0; i < NB; i++) begin
      exp_cdf += CW'(i + 1);
      checks++;
      if (b_bin[i] !== AW'(i) || b_cnt[i] !== DW'(i + 1) || b_cdf[i] !== exp_cdf ||
          b_last[i] !== (i == NB - 1) || b_cyc[i] !== 3 + i) begin
        failures++;
        if (failures < 20) $display("[TB] FAIL noclr_beat%0d got bin=%0d cnt=%0d cdf=%0d last=%b cyc=%0d exp bin=%0d cnt=%0d cdf=%0d last=%b cyc=%0d",
          i, b_bin[i], b_cnt[i], b_cdf[i], b_last[i], b_cyc[i], i, i + 1, exp_cdf, (i == NB - 1), 3 + i);
      end
    end
    checks++; if (b_cdf[NB-1] !== 32896) begin failures++; $display("[TB] FAIL noclr_final_cdf got=%0d exp=32896", b_cdf[NB-1]); end
    checks++; if (done_cyc !== 259) begin failures++; $display("[TB] FAIL noclr_done_cycle got=%0d exp=259", done_cyc); end
    checks++; if (done_pulses !== 1) begin failures++; $display("[TB] FAIL noclr_done_pulses got=%0d exp=1", done_pulses); end
    checks++; if (busy_at_done !== 1'b0) begin failures++; $display("[TB] FAIL noclr_busy_at_done got=%b exp=0", busy_at_done); end
    checks++; if (wr_count !== 0) begin failures++; $display("[TB] FAIL noclr_writes got=%0d exp=0", wr_count); end
    bad = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== DW'(i + 1)) bad++;
    checks++; if (bad !== 0) begin failures++; $display("[TB] FAIL noclr_ram_intact got=%0d bad words exp=0", bad); end
  endtask

  task automatic test_clear;
    logic [CW-1:0] exp_cdf;
    int bad_lo;
    int bad_hi;
    preload(1);
    run_scan(1'b1, 1'b0, 1'b0);
    checks++; if (timed_out) begin failures++; $display("[TB] FAIL clr_timeout got=1 exp=0"); end
    checks++; if (nbeats !== NB) begin failures++; $display("[TB] FAIL clr_beats got=%0d exp=%0d", nbeats, NB); end
    exp_cdf = '0;
    for (int i = 0; i < NB; i++) begin
      exp_cdf += CW'(i + 1);
      checks++;
      if (b_bin[i] !== AW'(i) || b_cnt[i] !== DW'(i + 1) || b_cdf[i] !== exp_cdf ||
          b_last[i] !== (i == NB - 1) || b_cyc[i] !== 3 + 2 * i) begin
        failures++;
        if (failures < 20) $display("[TB] FAIL clr_beat%0d got bin=%0d cnt=%0d cdf=%0d cyc=%0d exp bin=%0d cnt=%0d cdf=%0d cyc=%0d",
          i, b_bin[i], b_cnt[i], b_cdf[i], b_cyc[i], i, i + 1, exp_cdf, 3 + 2 * i);
      end
    end
    checks++; if (done_cyc !== 514) begin failures++; $display("[TB] FAIL clr_done_cycle got=%0d exp=514", done_cyc); end
    checks++; if (wr_count !== NB) begin failures++; $display("[TB] FAIL clr_writes got=%0d exp=%0d", wr_count, NB); end
    checks++; if (bad_wr !== 0) begin failures++; $display("[TB] FAIL clr_write_range got=%0d exp=0", bad_wr); end
    bad_lo = 0; bad_hi = 0;
    for (int i = 0; i < NB; i++) if (mem[i] !== '0) bad_lo++;
    for (int i = NB; i < 512; i++) if (mem[i] !== DW'(i + 1)) bad_hi++;
    checks++; if (bad_lo !== 0) begin failures++; $display("[TB] FAIL clr_ram_zeroed got=%0d nonzero exp=0", bad_lo); end
    checks++; if (bad_hi !== 0) begin failures++; $display("[TB] FAIL clr_ram_upper got=%0d changed exp=0", bad_hi); end
  endtask

  task automatic test_backpressure;
    logic [CW-1:0] exp_cdf;
    preload(1);
    run_scan(1'b0, 1'b1, 1'b0);
    checks++; if (timed_out) begin failures++; $display("[TB] FAIL bp_timeout got=1 exp=0"); end
    checks++; if (nbeats !== NB) begin failures++; $display("[TB] FAIL bp_beats got=%0d exp=%0d", nbeats, NB); end
    checks++; if (stall_viol !== 0) begin failures++; $display("[TB] FAIL bp_stall_stable got=%0d exp=0", stall_viol); end
    checks++; if (done_pulses !== 1) begin failures++; $display("[TB] FAIL bp_done_pulses got=%0d exp=1", done_pulses); end
    exp_cdf = '0;
    for (int i = 0; i < NB; i++) begin
      exp_cdf += CW'(i + 1);
      checks++;
      if (b_bin[i] !== AW'(i) || b_cnt[i] !== DW'(i + 1) || b_cdf[i] !== exp_cdf ||
          b_last[i] !== (i == NB - 1)) begin
        failures++;
        if (failures < 20) $display("[TB] FAIL bp_beat%0d got bin=%0d cnt=%0d cdf=%0d exp bin=%0d cnt=%0d cdf=%0d",
          i, b_bin[i], b_cnt[i], b_cdf[i], i, i + 1, exp_cdf);
      end
    end
  endtask

  task automatic test_saturation;
    preload(2);
    run_scan(1'b0, 1'b0, 1'b0);
    checks++; if (nbeats !== NB) begin failures++; $display("[TB] FAIL sat_beats got=%0d exp=%0d", nbeats, NB); end
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (b_cnt[i] !== 32'hFFFF_FFFF || b_cdf[i] !== 32'hFFFF_FFFF) begin
        failures++;
        if (failures < 20) $display("[TB] FAIL sat_beat%0d got cnt=%0h cdf=%0h exp cnt=ffffffff cdf=ffffffff",
          i, b_cnt[i], b_cdf[i]);
      end
    end
  endtask

  task automatic test_reset_mid_scan;
    logic [118:0] snap;
    logic [CW-1:0] exp_cdf;
    int bad_lo;
    int bad_hi;
    preload(1);
    @(negedge clk);
    start = 1'b1; clear_en = 1'b1; m_ready = 1'b1;
    for (int c = 1; c <= 201; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++; if (ram_addr !== AW'(100) || ram_wr_en !== 1'b0) begin
      failures++; $display("[TB] FAIL rstmid_read100 got addr=%0d wr_en=%b exp addr=100 wr_en=0", ram_addr, ram_wr_en);
    end
    rst = 1'b1;
    @(negedge clk);
    snap = {busy, done, ram_addr, ram_wr_en, ram_wr_data, m_valid, m_bin, m_count, m_cdf, m_last};
    checks++; if (snap !== '0) begin failures++; $display("[TB] FAIL rstmid_outputs got=%0h exp=0", snap); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    bad_lo = 0; bad_hi = 0;
    for (int i = 0; i < 100; i++) if (mem[i] !== '0) bad_lo++;
    for (int i = 100; i < 512; i++) if (mem[i] !== DW'(i + 1)) bad_hi++;
    checks++; if (bad_lo !== 0) begin failures++; $display("[TB] FAIL rstmid_cleared got=%0d nonzero exp=0", bad_lo); end
    checks++; if (bad_hi !== 0) begin failures++; $display("[TB] FAIL rstmid_intact got=%0d changed exp=0", bad_hi); end
    run_scan(1'b0, 1'b0, 1'b0);
    checks++; if (nbeats !== NB) begin failures++; $display("[TB] FAIL rstmid_rescan_beats got=%0d exp=%0d", nbeats, NB); end
    checks++; if (b_bin[0] !== '0 || b_cnt[0] !== '0) begin
      failures++; $display("[TB] FAIL rstmid_first_beat got bin=%0d cnt=%0d exp bin=0 cnt=0", b_bin[0], b_cnt[0]);
    end
    checks++; if (b_cnt[100] !== 101) begin failures++; $display("[TB] FAIL rstmid_bin100 got=%0d exp=101", b_cnt[100]); end
    exp_cdf = '0;
    for (int i = 100; i < NB; i++) exp_cdf += CW'(i + 1);
    checks++; if (b_cdf[NB-1] !== exp_cdf) begin
      failures++; $display("[TB] FAIL rstmid_final_cdf got=%0d exp=%0d", b_cdf[NB-1], exp_cdf);
    end
  endtask

  task automatic test_start_spam;
    preload(1);
    run_scan(1'b0, 1'b0, 1'b1);
    checks++; if (timed_out) begin failures++; $display("[TB] FAIL spam_timeout got=1 exp=0"); end
    checks++; if (done_pulses !== 1) begin failures++; $display("[TB] FAIL spam_done_pulses got=%0d exp=1", done_pulses); end
    checks++; if (nbeats !== NB) begin failures++; $display("[TB] FAIL spam_beats got=%0d exp=%0d", nbeats, NB); end
    checks++; if (wr_count !== 0) begin failures++; $display("[TB] FAIL spam_writes got=%0d exp=0", wr_count); end
    checks++; if (done_cyc !== 259) begin failures++; $display("[TB] FAIL spam_done_cycle got=%0d exp=259", done_cyc); end
    checks++; if (b_cdf[NB-1] !== 32896 || b_last[NB-1] !== 1'b1 || b_bin[0] !== '0) begin
      failures++; $display("[TB] FAIL spam_payload got cdf=%0d last=%b bin0=%0d exp cdf=32896 last=1 bin0=0",
        b_cdf[NB-1], b_last[NB-1], b_bin[0]);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear_en = 1'b0; m_ready = 1'b1;
    test_reset();
    test_no_clear();
    test_clear();
    test_backpressure();
    test_saturation();
    test_reset_mid_scan();
    test_start_spam();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hist_readout_clear.md
# hist_readout_clear

Histogram readout engine: the read/clear side of the dual-port histogram RAM (512 × 32, port B, no output register, one-cycle read latency). On a start pulse it scans bins 0..NUM_BINS-1 through RAM port B and streams each bin count with its running cumulative sum (CDF) on a valid/ready interface. When requested, it zeroes each bin after reading it, so the RAM is cleared for the next frame. It sits between the histogram RAM and downstream equalisation/threshold logic.

## Interface
Parameters:
- ADDR_WIDTH, 9, RAM address width
- DATA_WIDTH, 32, RAM word / bin count width
- NUM_BINS, 256, bins scanned (2..2^ADDR_WIDTH)
- CDF_WIDTH, 32, cumulative sum width (≥ DATA_WIDTH)

Ports:
- clk  in  1  single clock for the block and for RAM port B
- rst  in  1  synchronous, active-high reset
- start  in  1  scan request pulse; accepted only in IDLE
- clear_en  in  1  sampled together with an accepted start; 1 = zero each bin after reading it
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the scan completes
- ram_addr  out  ADDR_WIDTH  port B address
- ram_wr_en  out  1  port B write enable (clear writes only)
- ram_wr_data  out  DATA_WIDTH  constant 0
- ram_rd_data  in  DATA_WIDTH  port B read data, valid the cycle after a read address
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accept
- m_bin  out  ADDR_WIDTH  bin index of the beat
- m_count  out  DATA_WIDTH  bin count
- m_cdf  out  CDF_WIDTH  sum of counts for bins 0..m_bin inclusive, saturating
- m_last  out  1  high on the beat for bin NUM_BINS-1

## Operation
- FSM states: IDLE, READ, CLEAR, DRAIN.
- IDLE: ram_addr=0, ram_wr_en=0. On start: latch clear_en, zero the address counter and CDF accumulator, go to READ.
- READ: issue a read (ram_addr=bin, ram_wr_en=0) only when (fifo_occupancy − pop_this_cycle + reads_in_flight) < 2. Otherwise hold the address and stall.
  - After an issued read: if latched clear → CLEAR. Else if the bin was the last → DRAIN. Else increment the bin and stay in READ.
- CLEAR: ram_addr = same bin, ram_wr_en=1, ram_wr_data=0. Then increment the bin → READ, or → DRAIN if it was the last bin.
- Capture: on the cycle after an issued read, push {bin, ram_rd_data, cdf_next, last} into a 2-entry output FIFO.
  - cdf_next = min(cdf + ram_rd_data, 2^CDF_WIDTH−1).
- DRAIN: wait until the FIFO is empty and no read is in flight, then pulse done and go to IDLE.
- Output: m_* is the FIFO head. The payload stays stable while m_valid && !m_ready. A beat is lost neither on stall nor on reset release.
- start while busy is ignored, and clear_en is not re-sampled.
- The address never exceeds NUM_BINS−1. No write is issued to addresses ≥ NUM_BINS.
- Reset mid-scan: the FSM returns to IDLE and the FIFO is flushed. RAM contents are left as-is (bins already cleared stay zero, the rest stay intact). A later start restarts at bin 0.

## Timing
- Reset values: busy=0, done=0, ram_addr=0, ram_wr_en=0, ram_wr_data=0, m_valid=0, m_bin=0, m_count=0, m_cdf=0, m_last=0.
- Start seen at edge k: ram_addr=0 in cycle k+1, ram_rd_data valid in k+2, m_valid=1 in k+3.
- Throughput with m_ready=1: one beat per cycle when clear_en=0, one beat per 2 cycles when clear_en=1.
- done is asserted in the cycle after the m_last handshake. busy falls in the same cycle done is high.
- No clear, m_ready=1, NUM_BINS=256, start at edge 0: beats in cycles 3..258, done in cycle 259.

## Test plan
- RAM model with bin i = i+1, clear_en=0, m_ready=1 → 256 beats, m_count=i+1, m_cdf=(i+1)(i+2)/2, m_last only at bin 255 with m_cdf=32896, done in cycle 259, RAM unchanged.
- Same preload, clear_en=1 → identical beat payloads at one beat per 2 cycles. Afterwards words 0..255 = 0 and words 256..511 are untouched. ram_wr_en is never seen with an address ≥ 256.
- Same preload, m_ready random with 30% low → identical beat sequence. Payload stable across every stalled cycle. No duplicate or missing bins.
- All bins = 0xFFFF_FFFF, CDF_WIDTH=32 → m_cdf=0xFFFF_FFFF from bin 0 onward, with no wrap.
- Clear scan with rst asserted while bin 100 is issued → all outputs at reset values next cycle, bins 0..99 zero, bins 101..255 intact. A new start then outputs bin 0 first.
- start pulsed in every cycle of a scan → exactly one scan and one done pulse. clear_en toggling mid-scan has no effect.
